srlatch_monitor: RTL and testbench
==================================

// Module: srlatch_monitor
// PURPOSE
//  Clocked observer for an srlatch_nor instance: samples latch inputs s/r and outputs q/q_bar,
//  tracks the latch state, flags forbidden input (s=r=1) and output/input inconsistency,
//  and counts set/reset/forbidden events. Reader-side partner to the latch stimulus driver;
//  sits beside the latch in the top level and runs in the system clock domain.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer flops per sampled signal (min 2)
//  SETTLE_CYC   3   cycles after state entry before q/q_bar must match expectation (>=1)
//  CNT_W        8   width of each event counter (saturating)
// PORTS
//  clk          in   1      system clock, all flops rising-edge
//  rst          in   1      asynchronous, active-high reset
//  s            in   1      latch set input (async to clk)
//  r            in   1      latch reset input (async to clk)
//  q            in   1      latch output (async to clk)
//  q_bar        in   1      latch complementary output (async to clk)
//  clr          in   1      synchronous clear of counters
//  state        out  3      current monitor state (srlatch_pkg::mon_state_t)
//  err_forbid   out  1      1-cycle pulse on entry to ST_FORBID
//  err_mismatch out  1      1-cycle pulse, q/q_bar wrong after SETTLE_CYC
//  set_cnt      out  CNT_W  entries into ST_SET
//  rst_cnt      out  CNT_W  entries into ST_RST
//  forbid_cnt   out  CNT_W  entries into ST_FORBID
// BEHAVIOUR
//  - Reset: sync flops 0, state=ST_UNK, all counters 0, all pulses 0. Reset mid-operation
//    aborts settle timing; no pulse is generated by reset deassertion.
//  - s,r,q,q_bar each pass SYNC_STAGES flops -> s_y,r_y,q_y,qb_y. Input edge to state
//    change latency = SYNC_STAGES+1 cycles.
//  - FSM, evaluated every cycle on {s_y,r_y}:
//     10 -> ST_SET; 01 -> ST_RST; 11 -> ST_FORBID (from any state).
//     00 in ST_SET/ST_RST: hold.
//     00 in ST_FORBID: -> ST_RACE (macro on) or ST_UNK (macro off).
//     00 in ST_UNK/ST_RACE: q_y=1,qb_y=0 -> ST_SET; q_y=0,qb_y=1 -> ST_RST; else stay.
//       Entry via this resolution path counts as an entry (counter increments).
//  - Expected outputs: ST_SET {q,qb}=10; ST_RST 01; ST_FORBID 00; ST_UNK/ST_RACE no check.
//  - Settle counter resets to 0 on every state entry, saturates at SETTLE_CYC. When it
//    equals SETTLE_CYC and {q_y,qb_y} != expected, err_mismatch pulses once; re-armed only
//    by next state entry. Continuous 11 input stays in ST_FORBID (no re-entry, no recount).
//  - Counters increment by 1 on state entry (transition into state), saturate at
//    {CNT_W{1'b1}}. clr and increment in same cycle: clr wins (counter -> 0).
//  - err_forbid is registered: asserts the cycle state first reads ST_FORBID.
// CONFIGURATION
//  SRLATCH_MON_RACE_EN defined: state ST_RACE exists; output race_pulse (1 bit) pulses
//    1 cycle on entry to ST_RACE (11 -> 00 direct); resolved as per ST_UNK rules.
//  Undefined: no ST_RACE, no race_pulse port; 11 -> 00 goes to ST_UNK silently.
// STRUCTURE
//  Package srlatch_pkg: mon_state_t enum (ST_UNK=0, ST_SET=1, ST_RST=2, ST_FORBID=3,
//    ST_RACE=4), function exp_q(mon_state_t) returning expected {q,q_bar}.
//  Sub-module sync_ff #(STAGES,W): multi-flop synchronizer, one instance W=4.
// TESTING
//  1 rst=1 then release, s=r=0,q=0,qb=1 -> state ST_UNK then ST_RST; rst_cnt=1.
//  2 s=1,r=0,q=1,qb=0 held 10 cycles -> state ST_SET after SYNC_STAGES+1; set_cnt+1;
//    err_mismatch stays 0.
//  3 s=r=1, q=qb=0 -> err_forbid single pulse, forbid_cnt=1, state ST_FORBID; then s=r=0
//    -> ST_RACE + race_pulse (macro on) / ST_UNK (macro off).
//  4 s=1,r=0 but q held 0,qb=1 -> exactly one err_mismatch pulse SETTLE_CYC cycles after
//    ST_SET entry, none afterwards.
//  5 300 set/reset alternations, CNT_W=8 -> set_cnt,rst_cnt saturate at 255; clr
//    coincident with an entry -> counter reads 0.
//  6 rst asserted mid-settle in ST_SET with q wrong -> no err_mismatch; all outputs
//    return to reset values immediately (async).

Source files
------------

// File: rtl/srlatch_pkg.sv
// Shared types for the SR-latch monitor: state encoding and expected latch outputs.
// Macro SRLATCH_MON_RACE_EN adds the ST_RACE state.
package srlatch_pkg;

`ifdef SRLATCH_MON_RACE_EN
  typedef enum logic [2:0] {
    ST_UNK    = 3'd0,
    ST_SET    = 3'd1,
    ST_RST    = 3'd2,
    ST_FORBID = 3'd3,
    ST_RACE   = 3'd4
  } mon_state_t;
`else
  typedef enum logic [2:0] {
    ST_UNK    = 3'd0,
    ST_SET    = 3'd1,
    ST_RST    = 3'd2,
    ST_FORBID = 3'd3
  } mon_state_t;
`endif

  // Expected {q, q_bar}; states without a check return 00 and are masked by has_check.
  function automatic logic [1:0] exp_q(input mon_state_t st);
    case (st)
      ST_SET:  exp_q = 2'b10;
      ST_RST:  exp_q = 2'b01;
      default: exp_q = 2'b00;
    endcase
  endfunction

  function automatic logic has_check(input mon_state_t st);
    case (st)
      ST_SET, ST_RST, ST_FORBID: has_check = 1'b1;
      default:                   has_check = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/srlatch_monitor_sync_ff.sv
// Multi-flop synchronizer for a W-bit bundle of asynchronous signals.
module sync_ff #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_r [STAGES];

  // Shift chain: stage 0 captures the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_r[i] <= {W{1'b0}};
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/srlatch_monitor.sv
// Clocked observer for an SR NOR latch: state tracking, error pulses and event counters.
// Macro SRLATCH_MON_RACE_EN enables ST_RACE and the race_pulse output.
module srlatch_monitor
  import srlatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             q_bar,
  input  logic             clr,
  output mon_state_t       state,
  output logic             err_forbid,
  output logic             err_mismatch,
`ifdef SRLATCH_MON_RACE_EN
  output logic             race_pulse,
`endif
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt,
  output logic [CNT_W-1:0] forbid_cnt
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC);
  localparam logic [SW-1:0] SETTLE_PRE = SW'(SETTLE_CYC - 1);

  logic          s_y_s, r_y_s, q_y_s, qb_y_s;
  mon_state_t    state_r, state_nxt_s, resolve_s;
  logic          entry_s, mismatch_hit_s;
  logic [SW-1:0] settle_cnt_r;
  logic          fired_r;

  sync_ff #(.STAGES(SYNC_STAGES), .W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({s, r, q, q_bar}),
    .q   ({s_y_s, r_y_s, q_y_s, qb_y_s})
  );

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic clear);
    if (clear)                              cnt_next = {CNT_W{1'b0}};
    else if (inc && cnt != {CNT_W{1'b1}})   cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    else                                    cnt_next = cnt;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_UNK;
    else     state_r <= state_nxt_s;
  end

  // Next-state: input pair dominates, idle inputs resolve unknown states from the outputs.
  always_comb begin
    if (q_y_s && !qb_y_s)      resolve_s = ST_SET;
    else if (!q_y_s && qb_y_s) resolve_s = ST_RST;
    else                       resolve_s = state_r;
    state_nxt_s = state_r;
    case ({s_y_s, r_y_s})
      2'b10:   state_nxt_s = ST_SET;
      2'b01:   state_nxt_s = ST_RST;
      2'b11:   state_nxt_s = ST_FORBID;
      default: begin
        case (state_r)
`ifdef SRLATCH_MON_RACE_EN
          ST_FORBID:       state_nxt_s = ST_RACE;
          ST_UNK, ST_RACE: state_nxt_s = resolve_s;
`else
          ST_FORBID:       state_nxt_s = ST_UNK;
          ST_UNK:          state_nxt_s = resolve_s;
`endif
          default:         state_nxt_s = state_r;
        endcase
      end
    endcase
  end

  // Output decode: entry detection and the one-shot mismatch condition.
  always_comb begin
    entry_s        = (state_nxt_s != state_r);
    mismatch_hit_s = !entry_s && !fired_r && (settle_cnt_r >= SETTLE_PRE) &&
                     has_check(state_r) && ({q_y_s, qb_y_s} != exp_q(state_r));
  end

  // Settle timer, pulses and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt_r <= {SW{1'b0}};
      fired_r      <= 1'b0;
      err_forbid   <= 1'b0;
      err_mismatch <= 1'b0;
`ifdef SRLATCH_MON_RACE_EN
      race_pulse   <= 1'b0;
`endif
      set_cnt      <= {CNT_W{1'b0}};
      rst_cnt      <= {CNT_W{1'b0}};
      forbid_cnt   <= {CNT_W{1'b0}};
    end else begin
      if (entry_s)                        settle_cnt_r <= {SW{1'b0}};
      else if (settle_cnt_r != SETTLE_MAX) settle_cnt_r <= settle_cnt_r + {{(SW-1){1'b0}}, 1'b1};
      else                                settle_cnt_r <= settle_cnt_r;
      fired_r      <= entry_s ? 1'b0 : (fired_r | mismatch_hit_s);
      err_mismatch <= mismatch_hit_s;
      err_forbid   <= entry_s && (state_nxt_s == ST_FORBID);
`ifdef SRLATCH_MON_RACE_EN
      race_pulse   <= entry_s && (state_nxt_s == ST_RACE);
`endif
      set_cnt      <= cnt_next(set_cnt,    entry_s && (state_nxt_s == ST_SET),    clr);
      rst_cnt      <= cnt_next(rst_cnt,    entry_s && (state_nxt_s == ST_RST),    clr);
      forbid_cnt   <= cnt_next(forbid_cnt, entry_s && (state_nxt_s == ST_FORBID), clr);
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_srlatch_monitor.sv
// Self-checking bench for srlatch_monitor: directed scenarios plus random traffic vs a cycle model.
module tb_srlatch_monitor;
  import srlatch_pkg::*;

  localparam int SYNC   = 2;
  localparam int SETTLE = 3;
  localparam int CMAX   = 255;

  logic       clk = 1'b0;
  logic       rst, s, r, q, q_bar, clr;
  mon_state_t state;
  logic       err_forbid, err_mismatch;
`ifdef SRLATCH_MON_RACE_EN
  logic       race_pulse;
`endif
  logic [7:0] set_cnt, rst_cnt, forbid_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  srlatch_monitor #(.SYNC_STAGES(SYNC), .SETTLE_CYC(SETTLE), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .s            (s),
    .r            (r),
    .q            (q),
    .q_bar        (q_bar),
    .clr          (clr),
    .state        (state),
    .err_forbid   (err_forbid),
    .err_mismatch (err_mismatch),
`ifdef SRLATCH_MON_RACE_EN
    .race_pulse   (race_pulse),
`endif
    .set_cnt      (set_cnt),
    .rst_cnt      (rst_cnt),
    .forbid_cnt   (forbid_cnt)
  );

  // Reference model: history of sampled inputs, plus state/counters from the behavioural rules.
  logic [3:0] hist[$];
  mon_state_t m_state;
  int         m_set, m_rst, m_forbid, m_age;
  bit         m_fired, m_ef, m_em, m_rp;

  function automatic int sat(int v, bit inc, bit c);
    return c ? 0 : (inc ? ((v < CMAX) ? v + 1 : CMAX) : v);
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(4'b0000);
    m_state = ST_UNK;
    m_set = 0; m_rst = 0; m_forbid = 0; m_age = 0;
    m_fired = 1'b0; m_ef = 1'b0; m_em = 1'b0; m_rp = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] y;
    logic [1:0] want;
    mon_state_t nx;
    bit ent, chk_on;
    y = hist[0];
    if (y[3] && y[2])                         nx = ST_FORBID;
    else if (y[3])                            nx = ST_SET;
    else if (y[2])                            nx = ST_RST;
    else if (m_state == ST_SET || m_state == ST_RST) nx = m_state;
`ifdef SRLATCH_MON_RACE_EN
    else if (m_state == ST_FORBID)            nx = ST_RACE;
`else
    else if (m_state == ST_FORBID)            nx = ST_UNK;
`endif
    else if (y[1] && !y[0])                   nx = ST_SET;
    else if (!y[1] && y[0])                   nx = ST_RST;
    else                                      nx = m_state;
    ent    = (nx != m_state);
    chk_on = (m_state == ST_SET || m_state == ST_RST || m_state == ST_FORBID);
    want   = (m_state == ST_SET) ? 2'b10 : ((m_state == ST_RST) ? 2'b01 : 2'b00);
    m_ef   = ent && nx == ST_FORBID;
`ifdef SRLATCH_MON_RACE_EN
    m_rp   = ent && nx == ST_RACE;
`endif
    m_em    = !ent && !m_fired && (m_age + 1 >= SETTLE) && chk_on && (y[1:0] != want);
    m_fired = ent ? 1'b0 : (m_fired | m_em);
    m_age   = ent ? 0 : m_age + 1;
    m_set    = sat(m_set,    ent && nx == ST_SET,    clr);
    m_rst    = sat(m_rst,    ent && nx == ST_RST,    clr);
    m_forbid = sat(m_forbid, ent && nx == ST_FORBID, clr);
    m_state = nx;
    void'(hist.pop_front());
    hist.push_back({s, r, q, q_bar});
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",        32'(state),        32'(m_state));
    chk("err_forbid",   32'(err_forbid),   32'(m_ef));
    chk("err_mismatch", 32'(err_mismatch), 32'(m_em));
`ifdef SRLATCH_MON_RACE_EN
    chk("race_pulse",   32'(race_pulse),   32'(m_rp));
`endif
    chk("set_cnt",      32'(set_cnt),      32'(m_set));
    chk("rst_cnt",      32'(rst_cnt),      32'(m_rst));
    chk("forbid_cnt",   32'(forbid_cnt),   32'(m_forbid));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic vs, input logic vr, input logic vq, input logic vqb);
    s = vs; r = vr; q = vq; q_bar = vqb;
  endtask

  int cnt_a, cnt_b, entry_at, pulse_at;

  initial begin
    // 1: reset, then idle inputs with the latch showing reset
    rst = 1'b1; clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    model_reset();
    #1;
    check_all();
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("t1_unk", 32'(state), 32'(ST_UNK));
    step();
    chk("t1_rst", 32'(state), 32'(ST_RST));
    chk("t1_rst_cnt", 32'(rst_cnt), 32'd1);

    // 2: set with consistent outputs, latency SYNC+1
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step(); step();
    chk("t2_before", 32'(state), 32'(ST_RST));
    step();
    chk("t2_set", 32'(state), 32'(ST_SET));
    chk("t2_set_cnt", 32'(set_cnt), 32'd1);
    cnt_a = 0;
    repeat (7) begin step(); cnt_a += int'(err_mismatch); end
    chk("t2_no_mismatch", 32'(cnt_a), 32'd0);

    // 3: forbidden input, then release to 00
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    cnt_a = 0;
    repeat (8) begin step(); cnt_a += int'(err_forbid); end
    chk("t3_forbid_pulses", 32'(cnt_a), 32'd1);
    chk("t3_forbid_cnt", 32'(forbid_cnt), 32'd1);
    chk("t3_forbid_state", 32'(state), 32'(ST_FORBID));
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cnt_b = 0;
    repeat (3) begin
      step();
`ifdef SRLATCH_MON_RACE_EN
      cnt_b += int'(race_pulse);
`endif
    end
`ifdef SRLATCH_MON_RACE_EN
    chk("t3_race_state", 32'(state), 32'(ST_RACE));
    chk("t3_race_pulses", 32'(cnt_b), 32'd1);
`else
    chk("t3_unk_state", 32'(state), 32'(ST_UNK));
`endif
    repeat (3) step();

    // 4: set requested but outputs stuck at reset
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) step();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    entry_at = -1; pulse_at = -1; cnt_a = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (entry_at < 0 && m_state == ST_SET) entry_at = i;
      if (err_mismatch) begin cnt_a++; pulse_at = i; end
    end
    chk("t4_pulses", 32'(cnt_a), 32'd1);
    chk("t4_delay", 32'(pulse_at - entry_at), 32'(SETTLE));

    // 5: saturation, then clear coincident with a set entry
    repeat (300) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0); repeat (3) step();
      drive(1'b0, 1'b1, 1'b0, 1'b1); repeat (3) step();
    end
    chk("t5_set_sat", 32'(set_cnt), 32'd255);
    chk("t5_rst_sat", 32'(rst_cnt), 32'd255);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_clr_state", 32'(state), 32'(ST_SET));
    chk("t5_clr_set", 32'(set_cnt), 32'd0);
    chk("t5_clr_rst", 32'(rst_cnt), 32'd0);
    step();

    // random traffic against the model
    repeat (200) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(1, 8)) begin
        clr = ($urandom_range(0, 15) == 0);
        step();
      end
    end
    clr = 1'b0;

    // 6: async reset during settle with wrong outputs
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) step();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) step();
    chk("t6_pre_state", 32'(state), 32'(ST_SET));
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_async_state", 32'(state), 32'(ST_UNK));
    chk("t6_async_set", 32'(set_cnt), 32'd0);
    chk("t6_async_rst", 32'(rst_cnt), 32'd0);
    chk("t6_async_mm", 32'(err_mismatch), 32'd0);
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
